// File: rtl/uart_tx_pacer.sv
`timescale 1ns/1ps
// Transmit pacer: arbitrates direct echo bytes (priority) over the transmit FIFO and
// issues one-cycle UART strobes, with a busy-start timeout and a programmable gap.
module uart_tx_pacer #(
    parameter logic [15:0] GAP           = 16'hfff,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        fifo_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read,
    input  logic        direct_valid,
    input  logic [7:0]  direct_byte,
    output logic        direct_ready,
    output logic        uart_transmit,
    output logic [7:0]  uart_tx_byte,
    input  logic        uart_busy,
    output logic        busy,
    output logic [15:0] sent_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    localparam logic [15:0] TIMEOUT_LOAD = 16'(START_TIMEOUT);

    state_t      state;
    logic [15:0] timeout_cnt;
    logic [15:0] gap_cnt;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state         <= ST_IDLE;
            fifo_read     <= 1'b0;
            direct_ready  <= 1'b0;
            uart_transmit <= 1'b0;
            busy          <= 1'b0;
            uart_tx_byte  <= 8'h00;
            sent_count    <= 16'h0000;
            timeout_cnt   <= 16'h0000;
            gap_cnt       <= 16'h0000;
        end else begin
            // NOTE: pulse outputs default low here so every branch below yields a one-cycle strobe.
            fifo_read     <= 1'b0;
            direct_ready  <= 1'b0;
            uart_transmit <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (direct_valid) begin
                        uart_tx_byte <= direct_byte;
                        direct_ready <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_SEND;
                    end else if (fifo_en && !fifo_empty) begin
                        uart_tx_byte <= fifo_data;
                        fifo_read    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    uart_transmit <= 1'b1;
                    sent_count    <= sent_count + 16'd1;
                    timeout_cnt   <= TIMEOUT_LOAD;
                    state         <= ST_WAIT_START;
                end

                // A UART that never raises busy is assumed started once the timeout runs out.
                ST_WAIT_START: begin
                    if (uart_busy) begin
                        state <= ST_WAIT_DONE;
                    end else begin
                        timeout_cnt <= (timeout_cnt == 16'd0) ? 16'd0 : timeout_cnt - 16'd1;
                        if (timeout_cnt <= 16'd1) begin
                            state <= ST_WAIT_DONE;
                        end
                    end
                end

                ST_WAIT_DONE: begin
                    if (!uart_busy) begin
                        if (GAP == 16'd0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= GAP;
                            state   <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt <= 16'd1) begin
                        gap_cnt <= 16'd0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_pacer.sv
`timescale 1ns/1ps
// Bench for uart_tx_pacer: bench-owned FIFO and UART models, strobe timing predicted
// from the byte period formula, and a directed sequence with randomized transfers.
module tb_uart_tx_pacer;

    localparam logic [15:0] GAP = 16'd16;
    localparam int          ST  = 4;

    logic        CLK;
    logic        reset;
    logic        fifo_en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_read;
    logic        direct_valid;
    logic [7:0]  direct_byte;
    logic        direct_ready;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        uart_busy;
    logic        busy;
    logic [15:0] sent_count;

    uart_tx_pacer #(.GAP(GAP), .START_TIMEOUT(ST)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .fifo_en      (fifo_en),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read    (fifo_read),
        .direct_valid (direct_valid),
        .direct_byte  (direct_byte),
        .direct_ready (direct_ready),
        .uart_transmit(uart_transmit),
        .uart_tx_byte (uart_tx_byte),
        .uart_busy    (uart_busy),
        .busy         (busy),
        .sent_count   (sent_count)
    );

    int          n_vec;
    int          n_err;
    int          cyc;
    logic [15:0] sent_exp;

    // FIFO contents are written by the stimulus; the monitor owns the read pointer.
    logic [7:0]  fifo_mem[$];
    int          rd_ptr;
    int          n_reads;
    int          n_bad_pop;
    int          n_bad_width;
    int          strobe_cyc[$];
    logic [7:0]  strobe_byte[$];
    logic        prev_tx;

    bit          uart_respond;
    int          uart_frame;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed still running, required finished");
        $fatal(1, "watchdog expired");
    end

    // Monitor: services pops, records strobes, then presents the FIFO head for the next edge.
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        prev_tx    = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            if (fifo_read) begin
                if (rd_ptr >= fifo_mem.size()) n_bad_pop++;
                else rd_ptr++;
                n_reads++;
            end
            if (uart_transmit) begin
                if (prev_tx) n_bad_width++;
                strobe_cyc.push_back(cyc);
                strobe_byte.push_back(uart_tx_byte);
            end
            prev_tx    = uart_transmit;
            fifo_empty = (rd_ptr >= fifo_mem.size());
            fifo_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
        end
    end

    // UART model: registers the strobe, then reports busy for uart_frame cycles.
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (uart_transmit && uart_respond) begin
                @(negedge CLK);
                uart_busy = 1'b1;
                repeat (uart_frame) @(negedge CLK);
                uart_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe-to-strobe period for back-to-back bytes: request, send, start, frame, gap, idle.
    function automatic int period(input bit resp, input int f);
        return resp ? (2 + 1 + f + int'(GAP) + 1) : (2 + ST + int'(GAP) + 1);
    endfunction

    task automatic wait_strobes(input int n, input int budget);
        int g = 0;
        while (strobe_cyc.size() < n && g < budget) begin
            @(negedge CLK);
            g++;
        end
        chk("strobe_timeout", strobe_cyc.size() >= n, 1);
    endtask

    task automatic wait_idle(output int at);
        int g = 0;
        while (busy !== 1'b0 && g < 400) begin
            @(negedge CLK);
            g++;
        end
        chk("idle_timeout", busy, 0);
        at = cyc;
    endtask

    task automatic run_one(input bit use_direct, input logic [7:0] b, input bit resp, input int f);
        int base;
        int c;
        int reads0;
        int idle_at;
        uart_respond = resp;
        uart_frame   = f;
        base   = strobe_cyc.size();
        reads0 = n_reads;
        c      = cyc;
        if (use_direct) begin
            direct_valid = 1'b1;
            direct_byte  = b;
            @(negedge CLK);
            chk("direct_ready_pulse", direct_ready, 1);
            direct_valid = 1'b0;
            direct_byte  = ~b;
            @(negedge CLK);
            chk("direct_ready_drop", direct_ready, 0);
        end else begin
            fifo_mem.push_back(b);
        end
        wait_strobes(base + 1, 20);
        sent_exp++;
        if (strobe_cyc.size() > base) begin
            chk("latency", strobe_cyc[base], c + 2);
            chk("tx_byte", strobe_byte[base], b);
        end
        chk("sent_count", sent_count, sent_exp);
        wait_idle(idle_at);
        if (strobe_cyc.size() > base) chk("idle_delay", idle_at - strobe_cyc[base], period(resp, f) - 2);
        chk("read_count", n_reads - reads0, use_direct ? 0 : 1);
    endtask

    task automatic check_burst(input int base, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int n, input int per);
        logic [7:0] exp_b[3];
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
        for (int i = 0; i < n; i++) begin
            if (strobe_cyc.size() > base + i) begin
                chk("burst_byte", strobe_byte[base + i], exp_b[i]);
                if (i > 0) chk("burst_spacing", strobe_cyc[base + i] - strobe_cyc[base + i - 1], per);
            end
        end
    endtask

    initial begin
        int base;
        int reads0;
        int idle_at;
        int g;
        logic [7:0] r0, r1, r2;

        reset        = 1'b0;
        fifo_en      = 1'b1;
        direct_valid = 1'b0;
        direct_byte  = 8'h00;
        uart_respond = 1'b1;
        uart_frame   = 8;
        sent_exp     = 16'h0000;

        repeat (3) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_transmit", uart_transmit, 0);
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_direct_ready", direct_ready, 0);
        chk("rst_tx_byte", uart_tx_byte, 0);
        chk("rst_sent_count", sent_count, 0);
        reset = 1'b1;
        @(negedge CLK);

        run_one(1'b1, 8'h41, 1'b1, 12);

        // FIFO drain, UART busy for 20 cycles per byte.
        uart_respond = 1'b1;
        uart_frame   = 20;
        base   = strobe_cyc.size();
        reads0 = n_reads;
        fifo_mem.push_back(8'h01);
        fifo_mem.push_back(8'h02);
        fifo_mem.push_back(8'h03);
        wait_strobes(base + 3, 400);
        sent_exp += 16'd3;
        check_burst(base, 8'h01, 8'h02, 8'h03, 3, period(1'b1, 20));
        wait_idle(idle_at);
        chk("drain_reads", n_reads - reads0, 3);
        chk("drain_sent_count", sent_count, sent_exp);

        // Direct and FIFO requests in the same cycle: direct first, FIFO byte stays queued.
        uart_frame   = 6;
        base   = strobe_cyc.size();
        reads0 = n_reads;
        direct_valid = 1'b1;
        direct_byte  = 8'hAA;
        fifo_mem.push_back(8'h55);
        @(negedge CLK);
        chk("simul_ready", direct_ready, 1);
        chk("simul_no_read", fifo_read, 0);
        direct_valid = 1'b0;
        wait_strobes(base + 2, 200);
        sent_exp += 16'd2;
        check_burst(base, 8'hAA, 8'h55, 8'h00, 2, period(1'b1, 6));
        wait_idle(idle_at);
        chk("simul_reads", n_reads - reads0, 1);

        // UART never reports busy: the start timeout paces the bytes.
        uart_respond = 1'b0;
        base   = strobe_cyc.size();
        reads0 = n_reads;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        fifo_mem.push_back(r0);
        fifo_mem.push_back(r1);
        fifo_mem.push_back(r2);
        wait_strobes(base + 3, 200);
        sent_exp += 16'd3;
        check_burst(base, r0, r1, r2, 3, period(1'b0, 0));
        wait_idle(idle_at);
        chk("timeout_reads", n_reads - reads0, 3);

        for (int i = 0; i < 8; i++) begin
            run_one(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 30)));
        end

        // Reset while waiting for the UART to finish.
        uart_respond = 1'b1;
        uart_frame   = 20;
        base = strobe_cyc.size();
        direct_valid = 1'b1;
        direct_byte  = 8'h3C;
        @(negedge CLK);
        direct_valid = 1'b0;
        wait_strobes(base + 1, 20);
        repeat (5) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk("rst2_busy", busy, 0);
        chk("rst2_transmit", uart_transmit, 0);
        chk("rst2_fifo_read", fifo_read, 0);
        chk("rst2_direct_ready", direct_ready, 0);
        chk("rst2_tx_byte", uart_tx_byte, 0);
        chk("rst2_sent_count", sent_count, 0);
        g = 0;
        while (uart_busy && g < 50) begin
            @(negedge CLK);
            g++;
        end
        reset    = 1'b1;
        sent_exp = 16'h0000;
        @(negedge CLK);
        run_one(1'b0, 8'h7E, 1'b1, 5);

        // Counter wrap from a preloaded value.
        force dut.sent_count = 16'hfffe;
        @(negedge CLK);
        release dut.sent_count;
        sent_exp = 16'hfffe;
        @(negedge CLK);
        chk("wrap_preload", sent_count, 16'hfffe);
        run_one(1'b1, 8'hF0, 1'b1, 3);
        run_one(1'b0, 8'h0F, 1'b0, 1);
        chk("wrap_zero", sent_count, 16'h0000);

        // FIFO disabled: queued byte is left alone, direct path still works.
        fifo_en = 1'b0;
        fifo_mem.push_back(8'h99);
        reads0 = n_reads;
        repeat (1000) @(negedge CLK);
        chk("fifo_en_reads", n_reads - reads0, 0);
        chk("fifo_en_busy", busy, 0);
        run_one(1'b1, 8'hC3, 1'b1, 4);
        chk("fifo_en_reads_after", n_reads - reads0, 0);

        chk("pop_while_empty", n_bad_pop, 0);
        chk("strobe_width", n_bad_width, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
